// File: rtl/count_sequencer.sv
// Sequences the N-phase and M-phase counters for LOOPS passes after a start edge.
// It pulses bis_end for one cycle on completion and supports a synchronous abort.
module count_sequencer #(
    parameter int N_MAX = 5,
    parameter int M_MAX = 12,
    parameter int LOOPS = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    output logic       out,
    output logic       running,
    output logic       bis_end,
    output logic [1:0] phase,
    output logic [2:0] count_n,
    output logic [3:0] count_m,
    output logic [3:0] loop_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN_N  = 2'd1,
        RUN_M  = 2'd2,
        FINISH = 2'd3
    } state_t;

    localparam logic [2:0] N_TERM    = 3'(N_MAX);
    localparam logic [3:0] M_TERM    = 4'(M_MAX);
    localparam logic [3:0] LOOP_LAST = 4'(LOOPS - 1);

    state_t     state_reg, state_next;
    logic [2:0] count_n_reg, count_n_next;
    logic [3:0] count_m_reg, count_m_next;
    logic [3:0] loop_cnt_reg, loop_cnt_next;
    logic       start_prev_reg;
    logic       start_rise;

    assign start_rise = start & ~start_prev_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= IDLE;
            count_n_reg    <= '0;
            count_m_reg    <= '0;
            loop_cnt_reg   <= '0;
            start_prev_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            count_n_reg    <= count_n_next;
            count_m_reg    <= count_m_next;
            loop_cnt_reg   <= loop_cnt_next;
            start_prev_reg <= start;
        end
    end

    always_comb begin
        state_next    = state_reg;
        count_n_next  = count_n_reg;
        count_m_next  = count_m_reg;
        loop_cnt_next = loop_cnt_reg;
        case (state_reg)
            IDLE: begin
                if (start_rise && !abort) begin
                    state_next    = RUN_N;
                    count_n_next  = '0;
                    count_m_next  = '0;
                    loop_cnt_next = '0;
                end
            end
            RUN_N: begin
                // abort takes priority over the terminal count
                if (abort) begin
                    state_next    = IDLE;
                    count_n_next  = '0;
                    count_m_next  = '0;
                    loop_cnt_next = '0;
                end else if (count_n_reg == N_TERM) begin
                    count_n_next = '0;
                    state_next   = RUN_M;
                end else begin
                    count_n_next = count_n_reg + 3'd1;
                end
            end
            RUN_M: begin
                if (abort) begin
                    state_next    = IDLE;
                    count_n_next  = '0;
                    count_m_next  = '0;
                    loop_cnt_next = '0;
                end else if (count_m_reg == M_TERM) begin
                    count_m_next = '0;
                    if (loop_cnt_reg == LOOP_LAST) begin
                        state_next = FINISH;
                    end else begin
                        loop_cnt_next = loop_cnt_reg + 4'd1;
                        state_next    = RUN_N;
                    end
                end else begin
                    count_m_next = count_m_reg + 4'd1;
                end
            end
            FINISH: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign out      = (state_reg == RUN_N);
    assign running  = (state_reg == RUN_N) || (state_reg == RUN_M);
    assign bis_end  = (state_reg == FINISH);
    assign phase    = state_reg;
    assign count_n  = count_n_reg;
    assign count_m  = count_m_reg;
    assign loop_cnt = loop_cnt_reg;

endmodule

// File: tb/tb_count_sequencer.sv
// Directed bench for count_sequencer: default instance plus a minimal N=0/M=0/LOOPS=1 instance.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_count_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       abort;
    logic       out, running, bis_end;
    logic [1:0] phase;
    logic [2:0] count_n;
    logic [3:0] count_m;
    logic [3:0] loop_cnt;

    logic       start2;
    logic       out2, running2, bis_end2;
    logic [1:0] phase2;
    logic [2:0] count_n2;
    logic [3:0] count_m2;
    logic [3:0] loop_cnt2;

    int checks = 0;
    int errors = 0;
    int run_cnt, out_cnt, bis_cnt, bis_idx;
    int ph_hist [0:199];

    always #5 clk = ~clk;

    count_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .out(out), .running(running), .bis_end(bis_end), .phase(phase),
        .count_n(count_n), .count_m(count_m), .loop_cnt(loop_cnt)
    );

    count_sequencer #(.N_MAX(0), .M_MAX(0), .LOOPS(1)) dut_min (
        .clk(clk), .reset(reset), .start(start2), .abort(1'b0),
        .out(out2), .running(running2), .bis_end(bis_end2), .phase(phase2),
        .count_n(count_n2), .count_m(count_m2), .loop_cnt(loop_cnt2)
    );

    task automatic chk(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic clear_stats();
        run_cnt = 0;
        out_cnt = 0;
        bis_cnt = 0;
        bis_idx = -1;
    endtask

    task automatic sample(input int i);
        if (running) run_cnt++;
        if (out) out_cnt++;
        if (bis_end) begin
            bis_cnt++;
            bis_idx = i;
        end
        if (i < 200) ph_hist[i] = int'(phase);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset  = 1'b0;
        start  = 1'b0;
        abort  = 1'b0;
        start2 = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_phase", int'(phase), 0);
        chk("rst_running", int'(running), 0);
        chk("rst_out", int'(out), 0);
        chk("rst_bis_end", int'(bis_end), 0);
        chk("rst_counts", int'({count_n, count_m, loop_cnt}), 0);
        reset = 1'b1;
        @(negedge clk);

        // single one-cycle start pulse
        $display("T1 single start pulse");
        start = 1'b1;
        clear_stats();
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            if (i == 0) start = 1'b0;
            sample(i);
            if (i == 3)  chk("t1_count_n_i3", int'(count_n), 3);
            if (i == 10) chk("t1_count_m_i10", int'(count_m), 4);
            if (i == 20) chk("t1_loop_cnt_i20", int'(loop_cnt), 1);
        end
        chk("t1_running_cycles", run_cnt, 38);
        chk("t1_out_cycles", out_cnt, 12);
        chk("t1_bis_cycles", bis_cnt, 1);
        chk("t1_bis_index", bis_idx, 38);
        chk("t1_phase_i0", ph_hist[0], 1);
        chk("t1_phase_i5", ph_hist[5], 1);
        chk("t1_phase_i6", ph_hist[6], 2);
        chk("t1_phase_i19", ph_hist[19], 1);
        chk("t1_phase_i25", ph_hist[25], 2);
        chk("t1_phase_i38", ph_hist[38], 3);
        chk("t1_phase_i39", ph_hist[39], 0);

        // start held high for 100 cycles, then a fresh rise
        $display("T2 start held high");
        start = 1'b1;
        clear_stats();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            sample(i);
        end
        chk("t2_running_cycles", run_cnt, 38);
        chk("t2_bis_cycles", bis_cnt, 1);
        start = 1'b0;
        @(negedge clk);
        chk("t2_loop_cnt_hold", int'(loop_cnt), 1);
        start = 1'b1;
        clear_stats();
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            if (i == 0) begin
                start = 1'b0;
                chk("t2_restart_phase", int'(phase), 1);
                chk("t2_restart_loop_cnt", int'(loop_cnt), 0);
            end
            sample(i);
        end
        chk("t2_second_bis_cycles", bis_cnt, 1);
        chk("t2_second_running", run_cnt, 38);

        // abort while count_m==7 in loop 0
        $display("T3 abort in RUN_M");
        start = 1'b1;
        clear_stats();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (i == 0) start = 1'b0;
            if (i == 14) begin
                abort = 1'b0;
                chk("t3_phase_after_abort", int'(phase), 0);
                chk("t3_counts_after_abort", int'({count_n, count_m, loop_cnt}), 0);
                chk("t3_running_after_abort", int'(running), 0);
            end
            sample(i);
            if (i == 13) begin
                chk("t3_count_m_at_abort", int'(count_m), 7);
                chk("t3_loop_at_abort", int'(loop_cnt), 0);
                abort = 1'b1;
            end
        end
        chk("t3_bis_cycles", bis_cnt, 0);
        chk("t3_running_cycles", run_cnt, 14);

        // start rise together with abort in IDLE
        $display("T4 start with abort in IDLE");
        start = 1'b1;
        abort = 1'b1;
        clear_stats();
        @(negedge clk);
        chk("t4_idle_phase", int'(phase), 0);
        abort = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            sample(i);
        end
        chk("t4_no_start", run_cnt, 0);
        start = 1'b0;
        @(negedge clk);

        // start rise during RUN_M of loop 1 is ignored
        $display("T4 start rise during RUN_M");
        start = 1'b1;
        clear_stats();
        for (int i = 0; i < 46; i++) begin
            @(negedge clk);
            if (i == 0) start = 1'b0;
            if (i == 28) start = 1'b1;
            if (i == 30) start = 1'b0;
            sample(i);
        end
        chk("t4_running_cycles", run_cnt, 38);
        chk("t4_bis_index", bis_idx, 38);

        // asynchronous reset mid RUN_N
        $display("T5 async reset");
        start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i == 0) start = 1'b0;
        end
        chk("t5_pre_reset_count_n", int'(count_n), 2);
        #2;
        reset = 1'b0;
        #1;
        chk("t5_reset_phase", int'(phase), 0);
        chk("t5_reset_out", int'(out), 0);
        chk("t5_reset_running", int'(running), 0);
        chk("t5_reset_count_n", int'(count_n), 0);
        start = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("t5_restart_phase", int'(phase), 1);
        chk("t5_restart_count_n", int'(count_n), 0);
        start = 1'b0;
        clear_stats();
        for (int i = 1; i < 45; i++) begin
            @(negedge clk);
            sample(i);
        end
        chk("t5_bis_index", bis_idx, 38);

        // minimal configuration
        $display("T6 minimal instance");
        start2 = 1'b1;
        run_cnt = 0;
        bis_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 0) start2 = 1'b0;
            if (running2) run_cnt++;
            if (bis_end2) bis_cnt++;
            ph_hist[i] = int'(phase2);
        end
        chk("t6_phase_i0", ph_hist[0], 1);
        chk("t6_phase_i1", ph_hist[1], 2);
        chk("t6_phase_i2", ph_hist[2], 3);
        chk("t6_phase_i3", ph_hist[3], 0);
        chk("t6_running_cycles", run_cnt, 2);
        chk("t6_bis_cycles", bis_cnt, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
